// File: rtl/rf_selftest_seq.sv
// Register file self-test sequencer: writes a seeded pattern to every
// register, then reads each one back through both read ports and counts
// mismatches. Reports done/pass, a saturating error count and the first
// failing address.
module rf_selftest_seq #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter logic [31:0] SEED    = 32'hA5A5_0000,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] raddr_a,
    output logic [ADDR_W-1:0] raddr_b,
    input  logic [DATA_W-1:0] rdata_a,
    input  logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] raddr_a_q, raddr_a_d;
    logic [ADDR_W-1:0] raddr_b_q, raddr_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;

    logic [ADDR_W-1:0] idx_inc;
    logic              mism_a, mism_b;
    logic [8:0]        err_sum;

    // Write pattern: seed XOR the index replicated into every byte.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] i);
        logic [31:0] p;
        p = SEED ^ (32'(i) * 32'h0101_0101);
        return DATA_W'(p);
    endfunction

    // Expected read value; register 0 may be hardwired to zero.
    function automatic logic [DATA_W-1:0] exp_val(input logic [ADDR_W-1:0] i);
        if (R0_ZERO && (i == '0)) begin
            return '0;
        end
        return pat(i);
    endfunction

    assign idx_inc = idx_q + 1'b1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_a_d   = raddr_a_q;
        raddr_b_d   = raddr_b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        mism_a      = 1'b0;
        mism_b      = 1'b0;
        err_sum     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    idx_d       = '0;
                    we_d        = 1'b1;
                    waddr_d     = '0;
                    wdata_d     = pat('0);
                    raddr_a_d   = '0;
                    raddr_b_d   = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST) begin
                    state_d   = S_READ;
                    idx_d     = '0;
                    we_d      = 1'b0;
                    raddr_a_d = '0;
                    raddr_b_d = LAST;
                end else begin
                    idx_d   = idx_inc;
                    waddr_d = idx_inc;
                    wdata_d = pat(idx_inc);
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Port B walks the registers in reverse: NREG-1-idx == ~idx.
                mism_a  = (rdata_a != exp_val(idx_q));
                mism_b  = (rdata_b != exp_val(~idx_q));
                err_sum = 9'(err_cnt_q) + 9'(mism_a) + 9'(mism_b);
                err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
                // err_cnt saturates rather than wraps, so zero means no error yet.
                if (err_cnt_q == 8'd0) begin
                    if (mism_a) begin
                        first_err_d = idx_q;
                    end else if (mism_b) begin
                        first_err_d = ~idx_q;
                    end
                end
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 8'd0);
                end else begin
                    state_d   = S_READ;
                    idx_d     = idx_inc;
                    raddr_a_d = idx_inc;
                    raddr_b_d = ~idx_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_a_q   <= '0;
            raddr_b_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_a_q   <= raddr_a_d;
            raddr_b_q   <= raddr_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign we             = we_q;
    assign waddr          = waddr_q;
    assign wdata          = wdata_q;
    assign raddr_a        = raddr_a_q;
    assign raddr_b        = raddr_b_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_rf_selftest_seq.sv
// Bench for rf_selftest_seq: a behavioural register file with injectable
// faults, a write-stream scoreboard and a result scoreboard per run.
module tb_rf_selftest_seq;

    localparam logic [31:0] SEED = 32'hA5A5_0000;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] err;
        logic [4:0] first;
        logic       pass;
    } vec_t;

    typedef struct {
        logic [7:0] err;
        logic [4:0] first;
        logic       pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [4:0]  first_err;

    logic        start8;
    logic        we8;
    logic [7:0]  waddr8, raddr_a8, raddr_b8, first_err8;
    logic [31:0] wdata8;
    logic [31:0] rdata_ff;
    logic        busy8, done8, pass8;
    logic [7:0]  err_cnt8;

    // 0 normal, 1 write to addr 7 stored as 0, 2 port B stuck at 0, 3 all reads FFFF_FFFF
    logic [1:0]  mode;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    logic [36:0] wq[$];
    res_t        rq[$];

    always #5 clk = ~clk;

    assign rdata_ff = 32'hFFFF_FFFF;

    rf_selftest_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_addr(first_err)
    );

    rf_selftest_seq #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .we(we8), .waddr(waddr8), .wdata(wdata8),
        .raddr_a(raddr_a8), .raddr_b(raddr_b8),
        .rdata_a(rdata_ff), .rdata_b(rdata_ff),
        .busy(busy8), .done(done8), .pass(pass8),
        .err_cnt(err_cnt8), .first_err_addr(first_err8)
    );

    // Register file model, write side.
    always @(posedge clk) begin
        if (we) begin
            if (mode == 2'd1 && waddr == 5'd7) regs[waddr] <= 32'h0;
            else                               regs[waddr] <= wdata;
        end
    end

    // Register file model, combinational read side with R0 hardwired to 0.
    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];
        if (mode == 2'd2) rdata_b = 32'h0;
        if (mode == 2'd3) begin
            rdata_a = 32'hFFFF_FFFF;
            rdata_b = 32'hFFFF_FFFF;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Write-stream scoreboard: every write must match the next expected one.
    always @(negedge clk) begin
        if (we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got we=1 addr %0d expected no write at %0t", waddr, $time);
            end else begin
                logic [36:0] e;
                e = wq.pop_front();
                chk("write", {27'd0, waddr, wdata}, {27'd0, e});
                $display("write addr=%0d data=%08h", waddr, wdata);
            end
        end
    end

    task automatic push_writes();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] d;
            d = SEED ^ (32'(i) * 32'h0101_0101);
            wq.push_back({5'(i), d});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive start for one edge; returns at the negedge of cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit extra, output int cyc);
        cyc = 1;
        while (!done && cyc < 1000) begin
            if (cyc == 1)  chk("busy_c1", {63'd0, busy}, 64'd1);
            if (cyc == 4)  chk("write_c4", {27'd0, waddr, wdata}, {27'd0, 5'd3, 32'hA6A6_0303});
            if (cyc == 96) chk("busy_done_c96", {62'd0, busy, done}, 64'd2);
            if (extra && (cyc == 5 || cyc == 50)) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 after %0d cycles", cyc);
        end
    endtask

    task automatic check_res();
        res_t r;
        r = rq.pop_front();
        chk("err_cnt", 64'(err_cnt), 64'(r.err));
        chk("first_err_addr", 64'(first_err), 64'(r.first));
        chk("pass", {63'd0, pass}, {63'd0, r.pass});
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        $display("run result err_cnt=%0d first_err=%0d pass=%0b", err_cnt, first_err, pass);
    endtask

    initial begin
        vec_t vecs[4];
        int   cyc;

        vecs[0] = '{2'd0, 8'd0,  5'd0,  1'b1};
        vecs[1] = '{2'd1, 8'd2,  5'd7,  1'b0};
        vecs[2] = '{2'd2, 8'd31, 5'd31, 1'b0};
        vecs[3] = '{2'd3, 8'd64, 5'd0,  1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        start8 = 1'b0;
        mode   = 2'd0;
        do_reset();
        chk("reset_outputs", {we, waddr, wdata, raddr_a, raddr_b, busy, done, pass, err_cnt, first_err}, 64'd0);

        // Table-driven runs, one per register-file fault mode.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mode = vecs[i].mode;
            rq.push_back('{vecs[i].err, vecs[i].first, vecs[i].pass});
            push_writes();
            pulse_start();
            wait_done(1'b0, cyc);
            chk("done_cycle", 64'(cyc), 64'd97);
            check_res();
        end

        // start pulses during a run are ignored.
        do_reset();
        mode = 2'd0;
        rq.push_back('{8'd0, 5'd0, 1'b1});
        push_writes();
        pulse_start();
        wait_done(1'b1, cyc);
        chk("done_cycle_extra_starts", 64'(cyc), 64'd97);
        check_res();

        // start in DONE restarts: first a failing run, then a clean rerun.
        mode = 2'd1;
        rq.push_back('{8'd2, 5'd7, 1'b0});
        push_writes();
        pulse_start();
        wait_done(1'b0, cyc);
        check_res();
        mode = 2'd0;
        rq.push_back('{8'd0, 5'd0, 1'b1});
        push_writes();
        pulse_start();
        chk("restart_clears", {55'd0, done, err_cnt}, 64'd0);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        wait_done(1'b0, cyc);
        chk("done_cycle_restart", 64'(cyc), 64'd97);
        check_res();

        // Reset during READ aborts the run; a later start runs cleanly.
        do_reset();
        mode = 2'd0;
        push_writes();
        pulse_start();
        cyc = 1;
        while (cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_outputs", {we, waddr, wdata, raddr_a, raddr_b, busy, done, pass, err_cnt, first_err}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_after_reset", {62'd0, we, busy}, 64'd0);
        end
        rq.push_back('{8'd0, 5'd0, 1'b1});
        push_writes();
        pulse_start();
        wait_done(1'b0, cyc);
        chk("done_cycle_after_reset", 64'(cyc), 64'd97);
        check_res();

        // Saturation: 256 registers, every read mismatches, 512 errors.
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 2000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle_w8", 64'(cyc), 64'd769);
        chk("err_cnt_sat", 64'(err_cnt8), 64'd255);
        chk("first_err_w8", 64'(first_err8), 64'd0);
        chk("pass_w8", {63'd0, pass8}, 64'd0);
        $display("run8 result err_cnt=%0d first_err=%0d pass=%0b", err_cnt8, first_err8, pass8);

        chk("write_queue_empty", 64'(wq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_selftest_seq.md
Name: rf_selftest_seq

Overview:
- Upstream stimulus/check sequencer for the register file inside Top.
- On a start pulse it writes a deterministic pattern to every register through the write port, then reads every register back through both read ports and compares against expected values.
- Reports done, pass, an error count and the first failing address.
- Gives the Top-level bench a self-checking run driven only by clk and rst_n.

Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W.
- DATA_W, 32, register data width.
- SEED, 32'hA5A5_0000, XOR seed for the write pattern.
- R0_ZERO, 1, when 1 register 0 reads as 0 regardless of writes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; starts a run when in IDLE or DONE.
- we  out  1  register file write enable.
- waddr  out  ADDR_W  write address.
- wdata  out  DATA_W  write data.
- raddr_a  out  ADDR_W  read port A address.
- raddr_b  out  ADDR_W  read port B address.
- rdata_a  in  DATA_W  read port A data (combinational read in the register file).
- rdata_b  in  DATA_W  read port B data.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 if err_cnt==0.
- err_cnt  out  8  saturating mismatch count.
- first_err_addr  out  ADDR_W  address of the first mismatch (A checked before B in the same cycle).

Behaviour:
- Reset:
  - Synchronous active-low, clk and rst_n only. Single clock domain.
  - rst_n=0 at a rising edge forces IDLE. All outputs go to 0 (we, waddr, wdata, raddr_a/b, busy, done, pass, err_cnt, first_err_addr), and the index counter idx clears.
  - Reset mid-run aborts immediately; the next cycle is IDLE with we=0.
- Pattern:
  - pat(i) = SEED ^ (i * 32'h0101_0101), truncated to DATA_W.
  - exp(i) = 0 if R0_ZERO and i==0, else pat(i).
- All outputs are registered.
- States: IDLE, WRITE, READ, CHECK, DONE.
- IDLE: busy=0, done=0.
  - start=1 -> WRITE; idx=0, err_cnt=0, first_err_addr=0, pass=0.
- WRITE (one register per cycle): we=1, waddr=idx, wdata=pat(idx).
  - idx increments each cycle.
  - After idx==NREG-1: next state READ, idx=0, we=0.
- READ: raddr_a=idx, raddr_b=NREG-1-idx. Next state CHECK.
- CHECK: raddr_a/b are held.
  - Compare rdata_a with exp(idx) and rdata_b with exp(NREG-1-idx).
  - Each mismatch adds 1 to err_cnt, saturating at 255. Two mismatches in one cycle add 2, still saturating.
  - On the first mismatch of a run, latch first_err_addr: A's address if A mismatches, else B's.
  - Then: if idx==NREG-1, go to DONE; else idx+1 and go to READ.
- DONE: done=1, busy=0, pass=(err_cnt==0).
  - Values hold until start or reset.
  - start in DONE restarts exactly as from IDLE and clears done the following cycle.
- start while busy is ignored.
- start coincident with rst_n=0: reset wins.
- Timing (start sampled at edge 0):
  - WRITE occupies cycles 1..NREG.
  - READ/CHECK occupy cycles NREG+1 .. 3*NREG.
  - done=1 from cycle 3*NREG+1; with defaults that is cycle 97.
- busy is high in cycles 1..3*NREG.
- we is never high outside WRITE.

Test Plan:
- Reset, then start pulse with a correct register file (R0 hardwired 0):
  - Writes cycles 1..32, e.g. waddr=3, wdata=32'hA6A6_0303.
  - done=1 at cycle 97 with pass=1 and err_cnt=0.
- Register file with a write to address 7 dropped (reads 0):
  - Each of the 2 reads of addr 7 mismatches (once via A at idx 7, once via B at idx 24), giving err_cnt=2, first_err_addr=7, pass=0.
- Register file with read port B stuck at 0:
  - err_cnt=31 (idx 31 reads B addr 0, which expects 0), first_err_addr=31, pass=0.
- Assert rst_n=0 for one cycle at cycle 40 (during READ):
  - Next cycle state IDLE, all outputs 0, we stays 0.
  - A start after that completes a clean run, with done at start+97.
- start pulses at cycles 5 and 50 during a run:
  - Both ignored; done at cycle 97 only.
- start in DONE:
  - done drops next cycle, err_cnt clears, and a second run completes 96 cycles later.
- Every port mismatching (drive rdata constant 32'hFFFF_FFFF):
  - 64 mismatches, so err_cnt=64 (no saturation), first_err_addr=0.
- Saturation check: rerun with ADDR_W=8:
  - 512 mismatches, err_cnt saturates at 255.
